// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX among NUM_REQ byte sources
// Optional watchdog: define UART_ARB_WDOG_EN to abort frames that exceed TIMEOUT clocks.
module uart_tx_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          GW      = 2,
  parameter logic [31:0] TIMEOUT = 32'd8000
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_clear_req,
  output logic [GW-1:0]          grant_id,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [GW-1:0]      LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state;
  logic                 pick_found;
  logic [GW-1:0]        pick_idx;
  logic [7:0]           pick_byte;
  logic [NUM_REQ-1:0]   ack_onehot;

  assign ack_onehot = ONE << grant_id;

  // Round-robin search: first pass covers requesters above the last grant, second pass wraps to 0..grant_id
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_id;
    pick_byte  = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && req_valid[j] && (j > int'(grant_id))) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
        pick_byte  = req_data[8*j +: 8];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && req_valid[j] && (j <= int'(grant_id))) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
        pick_byte  = req_data[8*j +: 8];
      end
    end
  end

`ifdef UART_ARB_WDOG_EN
  logic [31:0] wdog;
  logic        wdog_hit;

  assign wdog_hit = (wdog >= (TIMEOUT - 32'd1));
`else
  // Without the watchdog the FSM waits on the UART indefinitely
  assign timeout_err = 1'b0;

  // TIMEOUT only matters with the watchdog; this empty block keeps the parameter referenced
  if (TIMEOUT == 32'd0) begin : g_timeout_unused
  end
`endif

  // Frame sequencer: grant in IDLE, hold tx_start until the UART goes busy, wait for frame end, ack
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state    <= S_IDLE;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= LAST_ID;
      arb_busy <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      wdog        <= 32'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          req_ack <= '0;
          if (pick_found) begin
            grant_id <= pick_idx;
            tx_data  <= pick_byte;
            tx_start <= 1'b1;
            arb_busy <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          // A UART already busy on entry counts as acceptance as well
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          tx_start <= 1'b0;
          if (tx_clear_req) begin
            req_ack <= ack_onehot;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          req_ack  <= '0;
          arb_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
`ifdef UART_ARB_WDOG_EN
      // Watchdog overrides the normal transition so a stuck UART still releases the requester
      if (state == S_START || state == S_BUSY) begin
        if (wdog_hit) begin
          wdog        <= 32'd0;
          timeout_err <= 1'b1;
          tx_start    <= 1'b0;
          req_ack     <= ack_onehot;
          state       <= S_DONE;
        end else begin
          wdog <= wdog + 32'd1;
        end
      end else begin
        wdog <= 32'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam logic [31:0] TO = 32'd100;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_clear_req;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  logic m_busy, m_clear, h_busy, h_clear;
  logic model_en, model_busy;
  assign tx_busy      = m_busy | h_busy;
  assign tx_clear_req = m_clear | h_clear;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  logic [3:0] exp_acks[$];

  uart_tx_arbiter #(.NUM_REQ(4), .GW(2), .TIMEOUT(TO)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req), .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each tx_start rise must carry the next expected byte, each ack the next expected id
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge axis_clk);
      if (tx_start === 1'b1 && !prev_start) begin
        if (exp_bytes.size() == 0) chk("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_bytes.pop_front()});
      end
      prev_start = (tx_start === 1'b1);
      if (req_ack !== 4'b0 && !$isunknown(req_ack)) begin
        if (exp_acks.size() == 0) chk("unexpected_ack", {28'h0, req_ack}, 32'h0);
        else chk("ack_id", {28'h0, req_ack}, {28'h0, exp_acks.pop_front()});
      end
    end
  end

  // UART model: go busy one clock after tx_start, finish the frame with a clear pulse
  initial begin
    m_busy = 1'b0; m_clear = 1'b0; model_busy = 1'b0;
    forever begin
      @(negedge axis_clk);
      if (model_en && tx_start === 1'b1 && !model_busy) begin
        model_busy = 1'b1;
        @(posedge axis_clk); #1 m_busy = 1'b1;
        repeat (3) @(posedge axis_clk);
        #1 m_clear = 1'b1; m_busy = 1'b0;
        @(posedge axis_clk); #1 m_clear = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  task automatic wait_ack(input string name, output int n);
    n = 0;
    do begin
      @(negedge axis_clk);
      n++;
    end while (req_ack == 4'b0 && n < 300);
    if (req_ack == 4'b0) chk({name, "_ack_timeout"}, 32'h0, 32'h1);
  endtask

  // Leaves the bench at a negedge with the DUT in BUSY
  task automatic wait_in_busy(input string name);
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      @(negedge axis_clk);
      n++;
    end
    chk({name, "_busy_seen"}, {31'h0, tx_busy}, 32'h1);
    @(negedge axis_clk);
    chk({name, "_in_busy"}, {30'h0, arb_busy, tx_start}, 32'h2);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  gnt;
    logic [7:0]  bval;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{4'b0011, 32'h4433_2211, 2'd0, 8'h11};
    vecs[1] = '{4'b1001, 32'h8877_6655, 2'd3, 8'h88};
    vecs[2] = '{4'b1001, 32'h0C0B_0A09, 2'd0, 8'h09};
    vecs[3] = '{4'b0001, 32'h0000_002D, 2'd0, 8'h2D};
    vecs[4] = '{4'b1000, 32'hE100_0000, 2'd3, 8'hE1};
    vecs[5] = '{4'b1111, 32'hD4C3_B2A1, 2'd0, 8'hA1};
    vecs[6] = '{4'b0110, 32'h0077_6600, 2'd1, 8'h66};
    vecs[7] = '{4'b0101, 32'h005A_00F0, 2'd2, 8'h5A};

    // Reset with all requesters pending
    axis_rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h0;
    h_busy = 1'b0; h_clear = 1'b0; model_en = 1'b1;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_req_ack", {28'h0, req_ack}, 32'h0);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_grant_id", {30'h0, grant_id}, 32'h3);
    chk("rst_arb_busy", {31'h0, arb_busy}, 32'h0);
    chk("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    req_valid = 4'h0; axis_rst_n = 1'b1;

    // Single requester: grant latency and ack
    @(negedge axis_clk);
    chk("single_idle_start", {31'h0, tx_start}, 32'h0);
    req_valid = 4'b0100; req_data = 32'h00A5_0000;
    exp_bytes.push_back(8'hA5); exp_acks.push_back(4'b0100);
    @(negedge axis_clk);
    chk("single_tx_start", {31'h0, tx_start}, 32'h1);
    chk("single_tx_data", {24'h0, tx_data}, 32'hA5);
    chk("single_grant", {30'h0, grant_id}, 32'h2);
    wait_ack("single", n);
    chk("single_ack", {28'h0, req_ack}, 32'h4);
    req_valid = 4'h0;
    @(negedge axis_clk);
    chk("single_ack_pulse", {28'h0, req_ack}, 32'h0);
    chk("single_back_idle", {31'h0, arb_busy}, 32'h0);

    // Table of round-robin patterns, applied in order from grant_id=2
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid; req_data = vecs[i].data;
      exp_bytes.push_back(vecs[i].bval); exp_acks.push_back(4'b0001 << vecs[i].gnt);
      wait_ack("vec", n);
      chk($sformatf("vec%0d_grant", i), {30'h0, grant_id}, {30'h0, vecs[i].gnt});
      req_valid = 4'h0;
      @(negedge axis_clk);
      chk($sformatf("vec%0d_idle", i), {31'h0, arb_busy}, 32'h0);
    end

    // Clear pulse during START is ignored; START waits for tx_busy
    model_en = 1'b0;
    req_valid = 4'b0001; req_data = 32'h0000_003C;
    exp_bytes.push_back(8'h3C); exp_acks.push_back(4'b0001);
    @(negedge axis_clk);
    h_clear = 1'b1;
    @(negedge axis_clk);
    h_clear = 1'b0;
    chk("start_clear_ignored", {28'h0, req_ack, tx_start}, 32'h1);
    h_busy = 1'b1;
    @(negedge axis_clk);
    h_busy = 1'b0;
    chk("start_to_busy", {30'h0, arb_busy, tx_start}, 32'h2);
    repeat (2) @(negedge axis_clk);
    chk("busy_waits_clear", {28'h0, req_ack}, 32'h0);
    h_clear = 1'b1;
    @(negedge axis_clk);
    h_clear = 1'b0; req_valid = 4'h0;
    chk("manual_ack", {28'h0, req_ack}, 32'h1);

    // Stale busy already high when START is entered
    @(negedge axis_clk);
    h_busy = 1'b1;
    req_valid = 4'b0010; req_data = 32'h0000_7E00;
    exp_bytes.push_back(8'h7E); exp_acks.push_back(4'b0010);
    @(negedge axis_clk);
    chk("stale_start", {31'h0, tx_start}, 32'h1);
    @(negedge axis_clk);
    chk("stale_accepted", {30'h0, arb_busy, tx_start}, 32'h2);
    h_busy = 1'b0; h_clear = 1'b1;
    @(negedge axis_clk);
    h_clear = 1'b0; req_valid = 4'h0;
    chk("stale_ack", {28'h0, req_ack}, 32'h2);
    model_en = 1'b1;
    @(negedge axis_clk);

    // Late change of data and valid while the frame is in flight
    req_valid = 4'b0100; req_data = 32'h0055_0000;
    exp_bytes.push_back(8'h55); exp_acks.push_back(4'b0100);
    wait_in_busy("late");
    req_data = 32'h00FF_0000; req_valid = 4'h0;
    chk("late_data_held", {24'h0, tx_data}, 32'h55);
    wait_ack("late", n);
    chk("late_ack", {28'h0, req_ack}, 32'h4);
    chk("late_data_at_ack", {24'h0, tx_data}, 32'h55);
    repeat (3) @(negedge axis_clk);

    // Reset in the middle of a frame: no ack, grant pointer restored
    req_valid = 4'b0001; req_data = 32'h0000_0077;
    exp_bytes.push_back(8'h77);
    wait_in_busy("midrst");
    axis_rst_n = 1'b0; req_valid = 4'h0;
    repeat (2) @(negedge axis_clk);
    chk("midrst_state", {27'h0, arb_busy, tx_start, req_ack}, 32'h0);
    chk("midrst_grant", {30'h0, grant_id}, 32'h3);
    axis_rst_n = 1'b1;
    n = 0;
    while (model_busy && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    repeat (2) @(negedge axis_clk);
    chk("midrst_clear_in_idle", {27'h0, arb_busy, tx_start, req_ack}, 32'h0);

    // Fairness with everyone pending from grant_id=3
    req_valid = 4'hF; req_data = 32'h1312_1110;
    exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'h13); exp_bytes.push_back(8'h10);
    exp_acks.push_back(4'h1); exp_acks.push_back(4'h2); exp_acks.push_back(4'h4);
    exp_acks.push_back(4'h8); exp_acks.push_back(4'h1);
    for (int k = 0; k < 5; k++) begin
      wait_ack("fair", n);
      chk($sformatf("fair%0d_grant", k), {30'h0, grant_id}, k % 4);
      if (k == 4) req_valid = 4'h0;
    end
    repeat (2) @(negedge axis_clk);

`ifdef UART_ARB_WDOG_EN
    // Stuck UART: watchdog fires after TIMEOUT clocks, acks, and moves on
    model_en = 1'b0;
    req_valid = 4'b0011; req_data = 32'h0000_BBAA;
    exp_bytes.push_back(8'hBB); exp_bytes.push_back(8'hAA);
    exp_acks.push_back(4'b0010); exp_acks.push_back(4'b0001);
    @(negedge axis_clk);
    chk("wdog_start", {31'h0, tx_start}, 32'h1);
    wait_ack("wdog1", n);
    chk("wdog_latency", n, 32'd100);
    chk("wdog_flag", {30'h0, timeout_err, tx_start}, 32'h2);
    chk("wdog_grant1", {30'h0, grant_id}, 32'h1);
    wait_ack("wdog2", n);
    req_valid = 4'h0;
    chk("wdog_grant2", {30'h0, grant_id}, 32'h0);
    chk("wdog_sticky", {31'h0, timeout_err}, 32'h1);
    axis_rst_n = 1'b0;
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    chk("wdog_rst_clears", {31'h0, timeout_err}, 32'h0);
`else
    chk("no_wdog_flag", {31'h0, timeout_err}, 32'h0);
`endif

    @(negedge axis_clk);
    chk("bytes_drained", exp_bytes.size(), 32'h0);
    chk("acks_drained", exp_acks.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
